// File: rtl/lc3_mem_io.sv
// Word-addressed memory plus LC3 keyboard/display device registers behind a
// request/ready handshake with a fixed, parameterised access latency.
module lc3_mem_io #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int LATENCY       = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_en,
  input  logic                     memwe,
  input  logic [ADDRESS_WIDTH-1:0] mar,
  input  logic [15:0]              mdr,
  output logic [15:0]              memOut,
  output logic                     mem_rdy,
  output logic                     busy,
  input  logic                     kb_valid,
  input  logic [7:0]               kb_data,
  output logic                     kb_ready,
  output logic                     kb_irq,
  output logic                     ddr_valid,
  output logic [7:0]               ddr_data,
  input  logic                     ddr_ready,
  output logic                     dsp_irq
);

  // state | meaning
  // IDLE  | waiting for mem_en; request latched on acceptance
  // BUSY  | counting down latency; access commits when cnt reaches 0
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [15:0]              wdata_q;
  logic                     we_q;
  logic [15:0]              memout_q, memout_d;
  logic                     rdy_q;
  logic                     kb_full_q, kb_full_d;
  logic                     kb_ie_q, kb_ie_d;
  logic [7:0]               kbdr_q, kbdr_d;
  logic                     dsp_ie_q, dsp_ie_d;
  logic                     ddr_valid_q, ddr_valid_d;
  logic [7:0]               ddr_data_q, ddr_data_d;

  logic [15:0] mem_q [2**ADDRESS_WIDTH];

  logic        accept, commit;
  logic [15:0] addr_ext;
  logic        is_kbsr, is_kbdr, is_dsr, is_ddr, is_mem;
  logic [15:0] rd_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With a narrow array the device addresses have high bits set and can never match.
  assign addr_ext = 16'(addr_q);
  assign is_kbsr  = (addr_ext == 16'hFE00);
  assign is_kbdr  = (addr_ext == 16'hFE02);
  assign is_dsr   = (addr_ext == 16'hFE04);
  assign is_ddr   = (addr_ext == 16'hFE06);
  assign is_mem   = ~(is_kbsr | is_kbdr | is_dsr | is_ddr);

  always_comb begin
    rd_data = 16'h0000;
    if (is_kbsr)      rd_data = {kb_full_q, kb_ie_q, 14'b0};
    else if (is_kbdr) rd_data = {8'h00, kbdr_q};
    else if (is_dsr)  rd_data = {~ddr_valid_q, dsp_ie_q, 14'b0};
    else if (is_ddr)  rd_data = 16'h0000;
    else              rd_data = mem_q[addr_q];
  end

  always_comb begin
    memout_d    = memout_q;
    kb_full_d   = kb_full_q;
    kb_ie_d     = kb_ie_q;
    kbdr_d      = kbdr_q;
    dsp_ie_d    = dsp_ie_q;
    ddr_valid_d = ddr_valid_q;
    ddr_data_d  = ddr_data_q;
    if (commit) begin
      if (!we_q) begin
        memout_d = rd_data;
        if (is_kbdr) kb_full_d = 1'b0;
      end else begin
        if (is_kbsr) kb_ie_d  = wdata_q[14];
        if (is_dsr)  dsp_ie_d = wdata_q[14];
        if (is_ddr && !ddr_valid_q) begin
          ddr_valid_d = 1'b1;
          ddr_data_d  = wdata_q[7:0];
        end
      end
    end
    // A freshly offered character wins over a same-edge KBDR read clear.
    if (kb_valid && !kb_full_q) begin
      kb_full_d = 1'b1;
      kbdr_d    = kb_data;
    end
    if (ddr_valid_q && ddr_ready) ddr_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      we_q        <= 1'b0;
      memout_q    <= 16'h0000;
      rdy_q       <= 1'b0;
      kb_full_q   <= 1'b0;
      kb_ie_q     <= 1'b0;
      kbdr_q      <= 8'h00;
      dsp_ie_q    <= 1'b0;
      ddr_valid_q <= 1'b0;
      ddr_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        addr_q  <= mar;
        wdata_q <= mdr;
        we_q    <= memwe;
      end
      memout_q    <= memout_d;
      rdy_q       <= commit;
      kb_full_q   <= kb_full_d;
      kb_ie_q     <= kb_ie_d;
      kbdr_q      <= kbdr_d;
      dsp_ie_q    <= dsp_ie_d;
      ddr_valid_q <= ddr_valid_d;
      ddr_data_q  <= ddr_data_d;
    end
  end

  // Array storage is deliberately not reset; an aborted access never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && we_q && is_mem) mem_q[addr_q] <= wdata_q;
  end

  assign memOut    = memout_q;
  assign mem_rdy   = rdy_q;
  assign busy      = (state_q == BUSY);
  assign kb_ready  = ~kb_full_q;
  assign kb_irq    = kb_full_q & kb_ie_q;
  assign ddr_valid = ddr_valid_q;
  assign ddr_data  = ddr_data_q;
  assign dsp_irq   = ~ddr_valid_q & dsp_ie_q;

endmodule

// File: tb/tb_lc3_mem_io.sv
// Directed bench for lc3_mem_io: three instances at LATENCY 1, 3 and 4.
module tb_lc3_mem_io;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst4_x;
  logic        rst4_n;
  logic        en [3];
  logic        memwe;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        ddr_ready;

  logic [15:0] mo      [3];
  logic        rdy     [3];
  logic        bsy     [3];
  logic        kb_rdy  [3];
  logic        kb_irq  [3];
  logic        ddr_vld [3];
  logic [7:0]  ddr_dat [3];
  logic        dsp_irq [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rst4_n = rst_n & rst4_x;

  lc3_mem_io #(.ADDRESS_WIDTH(16), .LATENCY(1)) u1 (
    .clk(clk), .reset(rst_n), .mem_en(en[0]), .memwe(memwe), .mar(mar), .mdr(mdr),
    .memOut(mo[0]), .mem_rdy(rdy[0]), .busy(bsy[0]),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_rdy[0]), .kb_irq(kb_irq[0]),
    .ddr_valid(ddr_vld[0]), .ddr_data(ddr_dat[0]), .ddr_ready(ddr_ready), .dsp_irq(dsp_irq[0]));

  lc3_mem_io #(.ADDRESS_WIDTH(16), .LATENCY(3)) u3 (
    .clk(clk), .reset(rst_n), .mem_en(en[1]), .memwe(memwe), .mar(mar), .mdr(mdr),
    .memOut(mo[1]), .mem_rdy(rdy[1]), .busy(bsy[1]),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_rdy[1]), .kb_irq(kb_irq[1]),
    .ddr_valid(ddr_vld[1]), .ddr_data(ddr_dat[1]), .ddr_ready(ddr_ready), .dsp_irq(dsp_irq[1]));

  lc3_mem_io #(.ADDRESS_WIDTH(16), .LATENCY(4)) u4 (
    .clk(clk), .reset(rst4_n), .mem_en(en[2]), .memwe(memwe), .mar(mar), .mdr(mdr),
    .memOut(mo[2]), .mem_rdy(rdy[2]), .busy(bsy[2]),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_rdy[2]), .kb_irq(kb_irq[2]),
    .ddr_valid(ddr_vld[2]), .ddr_data(ddr_dat[2]), .ddr_ready(ddr_ready), .dsp_irq(dsp_irq[2]));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic acc(input int s, input logic we, input logic [15:0] a,
                     input logic [15:0] d, output logic [15:0] rd);
    @(negedge clk);
    memwe = we; mar = a; mdr = d; en[s] = 1'b1;
    @(negedge clk);
    en[s] = 1'b0;
    for (int n = 0; n < 20 && !rdy[s]; n++) @(negedge clk);
    chk("acc_rdy", {15'b0, rdy[s]}, 16'h0001);
    rd = mo[s];
  endtask

  task automatic deliver(input logic [7:0] c);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = c;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  logic [15:0] rd;
  int          pulses;

  initial begin
    rst_n = 1'b0; rst4_x = 1'b1;
    en[0] = 1'b0; en[1] = 1'b0; en[2] = 1'b0;
    memwe = 1'b0; mar = 16'h0; mdr = 16'h0;
    kb_valid = 1'b0; kb_data = 8'h0; ddr_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_memOut",   mo[0], 16'h0000);
    chk("rst_rdy",      {15'b0, rdy[0]}, 16'h0000);
    chk("rst_busy",     {15'b0, bsy[0]}, 16'h0000);
    chk("rst_kb_ready", {15'b0, kb_rdy[0]}, 16'h0001);
    chk("rst_kb_irq",   {15'b0, kb_irq[0]}, 16'h0000);
    chk("rst_ddr_vld",  {15'b0, ddr_vld[0]}, 16'h0000);
    chk("rst_ddr_dat",  {8'b0, ddr_dat[0]}, 16'h0000);
    chk("rst_dsp_irq",  {15'b0, dsp_irq[0]}, 16'h0000);

    // LATENCY=1 write then read, with exact cycle timing
    memwe = 1'b1; mar = 16'h3000; mdr = 16'h1234; en[0] = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    chk("l1w_busy", {15'b0, bsy[0]}, 16'h0001);
    chk("l1w_rdy0", {15'b0, rdy[0]}, 16'h0000);
    @(negedge clk);
    chk("l1w_rdy1", {15'b0, rdy[0]}, 16'h0001);
    chk("l1w_idle", {15'b0, bsy[0]}, 16'h0000);
    chk("l1w_hold", mo[0], 16'h0000);
    @(negedge clk);
    chk("l1w_rdy_end", {15'b0, rdy[0]}, 16'h0000);
    memwe = 1'b0; mar = 16'h3000; en[0] = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    chk("l1r_rdy0", {15'b0, rdy[0]}, 16'h0000);
    @(negedge clk);
    chk("l1r_rdy1", {15'b0, rdy[0]}, 16'h0001);
    chk("l1r_data", mo[0], 16'h1234);

    // LATENCY=3 with mem_en held through BUSY
    acc(1, 1'b1, 16'h3000, 16'h00AA, rd);
    @(negedge clk);
    memwe = 1'b0; mar = 16'h3000; en[1] = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (rdy[1]) pulses++;
      if (i <= 3) chk("l3_busy_hi", {15'b0, bsy[1]}, 16'h0001);
      if (i == 4) begin
        chk("l3_rdy_at3", {15'b0, rdy[1]}, 16'h0001);
        chk("l3_busy_lo", {15'b0, bsy[1]}, 16'h0000);
        chk("l3_data", mo[1], 16'h00AA);
        en[1] = 1'b0;
      end
    end
    chk("l3_one_pulse", 16'(pulses), 16'h0001);

    // Keyboard
    deliver(8'h41);
    chk("kb_ready_lo", {15'b0, kb_rdy[0]}, 16'h0000);
    acc(0, 1'b0, 16'hFE00, 16'h0, rd); chk("kbsr_full", rd, 16'h8000);
    acc(0, 1'b0, 16'hFE02, 16'h0, rd); chk("kbdr", rd, 16'h0041);
    chk("kb_ready_hi", {15'b0, kb_rdy[0]}, 16'h0001);
    acc(0, 1'b0, 16'hFE00, 16'h0, rd); chk("kbsr_empty", rd, 16'h0000);

    // Display with sink stalled
    acc(0, 1'b1, 16'hFE06, 16'h0058, rd);
    chk("ddr_vld", {15'b0, ddr_vld[0]}, 16'h0001);
    chk("ddr_dat", {8'b0, ddr_dat[0]}, 16'h0058);
    acc(0, 1'b0, 16'hFE04, 16'h0, rd); chk("dsr_busy", rd, 16'h0000);
    acc(0, 1'b1, 16'hFE06, 16'h0059, rd);
    chk("ddr_drop", {8'b0, ddr_dat[0]}, 16'h0058);
    acc(0, 1'b0, 16'hFE06, 16'h0, rd); chk("ddr_read0", rd, 16'h0000);
    @(negedge clk); ddr_ready = 1'b1;
    @(negedge clk); ddr_ready = 1'b0;
    chk("ddr_drained", {15'b0, ddr_vld[0]}, 16'h0000);
    acc(0, 1'b0, 16'hFE04, 16'h0, rd); chk("dsr_ready", rd, 16'h8000);

    // Interrupt enables
    acc(0, 1'b1, 16'hFE00, 16'h4000, rd);
    chk("kb_irq_idle", {15'b0, kb_irq[0]}, 16'h0000);
    deliver(8'h42);
    chk("kb_irq_set", {15'b0, kb_irq[0]}, 16'h0001);
    acc(0, 1'b0, 16'hFE00, 16'h0, rd); chk("kbsr_ie_full", rd, 16'hC000);
    acc(0, 1'b0, 16'hFE02, 16'h0, rd); chk("kbdr2", rd, 16'h0042);
    chk("kb_irq_clr", {15'b0, kb_irq[0]}, 16'h0000);
    acc(0, 1'b1, 16'hFE04, 16'h4000, rd);
    chk("dsp_irq_set", {15'b0, dsp_irq[0]}, 16'h0001);
    acc(0, 1'b0, 16'hFE04, 16'h0, rd); chk("dsr_ie", rd, 16'hC000);

    // Reset mid-write at LATENCY=4
    acc(2, 1'b1, 16'h0010, 16'h1111, rd);
    @(negedge clk);
    memwe = 1'b1; mar = 16'h0010; mdr = 16'hBEEF; en[2] = 1'b1;
    @(negedge clk); en[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("l4_busy_pre", {15'b0, bsy[2]}, 16'h0001);
    rst4_x = 1'b0;
    #1;
    chk("l4_busy_rst", {15'b0, bsy[2]}, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rdy[2]) pulses++;
    end
    rst4_x = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy[2]) pulses++;
    end
    chk("l4_no_rdy", 16'(pulses), 16'h0000);
    acc(2, 1'b0, 16'h0010, 16'h0, rd); chk("l4_old_data", rd, 16'h1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
